// File: rtl/wtm_reset_sequencer_pkg.sv
// rtl/wtm_reset_sequencer_pkg.sv - shared state encoding, reset cause codes and counter sizing
package wtm_reset_sequencer_pkg;

    typedef enum logic [1:0] {
        S_HOLD   = 2'd0,
        S_PERIPH = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    // Also consumed by the CPU register-map block; 2'd3 is never produced.
    localparam logic [1:0] CAUSE_POWER  = 2'd0;
    localparam logic [1:0] CAUSE_BUTTON = 2'd1;
    localparam logic [1:0] CAUSE_SOFT   = 2'd2;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/wtm_reset_sequencer_if.sv
// rtl/wtm_reset_sequencer_if.sv - reset request inputs and staged reset outputs
interface wtm_reset_sequencer_if;
    logic       button_n;
    logic       soft_reset_req;
    logic       periph_rst;
    logic       cpu_rst_n;
    logic       ready;
    logic [1:0] reset_cause;

    modport master (
        input  button_n,
        input  soft_reset_req,
        output periph_rst,
        output cpu_rst_n,
        output ready,
        output reset_cause
    );

    modport slave (
        output button_n,
        output soft_reset_req,
        input  periph_rst,
        input  cpu_rst_n,
        input  ready,
        input  reset_cause
    );
endinterface

// File: rtl/wtm_debounce.sv
// rtl/wtm_debounce.sv - button 2-FF synchronizer with stable-count filter when WTM_RESET_DEBOUNCE_EN is defined
module wtm_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clock,
    input  logic rst,
    input  logic button_n,
    output logic pressed
);

    if (DEBOUNCE_CYCLES < 2) begin : g_param_check
        $error("wtm_debounce: DEBOUNCE_CYCLES must be >= 2");
    end

    // Synchronizer resets to the released level so rst never reads as a press.
    logic [1:0] sync_q;
    logic       btn_s;

    always_ff @(posedge clock) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], button_n};
        end
    end

    assign btn_s = ~sync_q[1];

`ifdef WTM_RESET_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [DW-1:0] stable_q;
    logic          pressed_q;

    always_ff @(posedge clock) begin
        if (rst) begin
            stable_q  <= '0;
            pressed_q <= 1'b0;
        end else if (btn_s == pressed_q) begin
            stable_q  <= '0;
        end else if (stable_q == DB_LAST) begin
            pressed_q <= btn_s;
            stable_q  <= '0;
        end else begin
            stable_q  <= stable_q + 1'b1;
        end
    end

    assign pressed = pressed_q;
`else
    assign pressed = btn_s;
`endif

endmodule

// File: rtl/wtm_reset_sequencer.sv
// rtl/wtm_reset_sequencer.sv - staged peripheral/CPU reset release with cause capture (debounce via WTM_RESET_DEBOUNCE_EN)
module wtm_reset_sequencer #(
    parameter int HOLD_CYCLES     = 1024,
    parameter int STAGE_GAP       = 16,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic                  clock,
    input  logic                  rst,
    wtm_reset_sequencer_if.master rs
);
    import wtm_reset_sequencer_pkg::*;

    localparam int CW = cnt_width(HOLD_CYCLES, STAGE_GAP);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_GAP - 1);

    logic          pressed;
    logic          trigger;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    cause_q, cause_d;
    logic          periph_rst_q, periph_rst_d;
    logic          cpu_rst_n_q, cpu_rst_n_d;
    logic          ready_q, ready_d;

    wtm_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock   (clock),
        .rst     (rst),
        .button_n(rs.button_n),
        .pressed (pressed)
    );

    assign trigger = pressed | rs.soft_reset_req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        // A held button re-enters here every cycle, pinning the counter at 0.
        if (trigger) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            cause_d = pressed ? CAUSE_BUTTON : CAUSE_SOFT;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = S_PERIPH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                S_PERIPH: begin
                    if (cnt_q == STAGE_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                S_RUN:   state_d = S_RUN;
                default: begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
        periph_rst_d = (state_d == S_HOLD);
        cpu_rst_n_d  = (state_d == S_RUN);
        ready_d      = (state_d == S_RUN);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= S_HOLD;
            cnt_q        <= '0;
            cause_q      <= CAUSE_POWER;
            periph_rst_q <= 1'b1;
            cpu_rst_n_q  <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cause_q      <= cause_d;
            periph_rst_q <= periph_rst_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            ready_q      <= ready_d;
        end
    end

    assign rs.periph_rst  = periph_rst_q;
    assign rs.cpu_rst_n   = cpu_rst_n_q;
    assign rs.ready       = ready_q;
    assign rs.reset_cause = cause_q;

endmodule

// File: tb/tb_wtm_reset_sequencer.sv
// tb/tb_wtm_reset_sequencer.sv - directed self-checking bench for wtm_reset_sequencer
module tb_wtm_reset_sequencer;

    localparam int HOLD = 8;
    localparam int GAP  = 4;
    localparam int DEB  = 16;
`ifdef WTM_RESET_DEBOUNCE_EN
    localparam int DB_LAT = DEB;
`else
    localparam int DB_LAT = 0;
`endif

    logic clock = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   bad;

    wtm_reset_sequencer_if rs_if ();

    wtm_reset_sequencer #(
        .HOLD_CYCLES    (HOLD),
        .STAGE_GAP      (GAP),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock(clock),
        .rst  (rst),
        .rs   (rs_if)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_out(input string tag, input logic p, input logic c, input logic r);
        check_eq({tag, " periph_rst"}, 32'(rs_if.periph_rst), 32'(p));
        check_eq({tag, " cpu_rst_n"},  32'(rs_if.cpu_rst_n),  32'(c));
        check_eq({tag, " ready"},      32'(rs_if.ready),      32'(r));
    endtask

    task automatic check_cause(input string tag, input logic [1:0] c);
        check_eq({tag, " reset_cause"}, 32'(rs_if.reset_cause), 32'(c));
    endtask

    // Call right after the edge that saw the last trigger/rst; next edge is count edge 1.
    task automatic release_seq(input string tag);
        step(HOLD - 1);
        check_out({tag, " hold"}, 1'b1, 1'b0, 1'b0);
        step(1);
        check_out({tag, " periph"}, 1'b0, 1'b0, 1'b0);
        step(GAP - 1);
        check_out({tag, " gap"}, 1'b0, 1'b0, 1'b0);
        step(1);
        check_out({tag, " run"}, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        rst                  = 1'b1;
        rs_if.button_n       = 1'b1;
        rs_if.soft_reset_req = 1'b0;

        // Power-up
        step(3);
        check_out("reset", 1'b1, 1'b0, 1'b0);
        check_cause("reset", 2'd0);
        rst = 1'b0;
        release_seq("powerup");
        check_cause("powerup", 2'd0);

        // Software reset from run
        rs_if.soft_reset_req = 1'b1;
        step(1);
        check_out("soft assert", 1'b1, 1'b0, 1'b0);
        check_cause("soft", 2'd2);
        rs_if.soft_reset_req = 1'b0;
        release_seq("soft");
        check_cause("soft done", 2'd2);

`ifdef WTM_RESET_DEBOUNCE_EN
        // Bounce every 5 cycles must never get through the filter
        bad = 0;
        for (int seg = 0; seg < 8; seg++) begin
            rs_if.button_n = (seg % 2 == 1);
            for (int k = 0; k < 5; k++) begin
                step(1);
                if (rs_if.periph_rst !== 1'b0 || rs_if.ready !== 1'b1) bad++;
            end
        end
        check_eq("bounce no reset", 32'(bad), 32'd0);
`endif

        // Stable press: asserted 2 + DB_LAT + 1 edges after button goes low
        rs_if.button_n = 1'b0;
        step(2 + DB_LAT);
        check_out("press pending", 1'b0, 1'b1, 1'b1);
        step(1);
        check_out("press assert", 1'b1, 1'b0, 1'b0);
        check_cause("press", 2'd1);
        bad = 0;
        for (int k = 0; k < 50 - (3 + DB_LAT); k++) begin
            step(1);
            if (rs_if.periph_rst !== 1'b1 || rs_if.cpu_rst_n !== 1'b0) bad++;
        end
        check_eq("held button keeps reset", 32'(bad), 32'd0);
        rs_if.button_n = 1'b1;
        step(2 + DB_LAT);
        check_out("button release pending", 1'b1, 1'b0, 1'b0);
        release_seq("button");
        check_cause("button done", 2'd1);

        // Trigger mid-way through the peripheral stage
        rs_if.soft_reset_req = 1'b1;
        step(1);
        rs_if.soft_reset_req = 1'b0;
        step(HOLD);
        check_out("mid periph cnt0", 1'b0, 1'b0, 1'b0);
        step(2);
        check_out("mid periph cnt2", 1'b0, 1'b0, 1'b0);
        rs_if.soft_reset_req = 1'b1;
        step(1);
        check_out("mid reassert", 1'b1, 1'b0, 1'b0);
        check_cause("mid", 2'd2);
        rs_if.soft_reset_req = 1'b0;
        release_seq("mid restart");

        // rst while running clears the cause
        check_cause("pre rst", 2'd2);
        rst = 1'b1;
        step(1);
        check_out("rst in run", 1'b1, 1'b0, 1'b0);
        check_cause("rst in run", 2'd0);
        rst = 1'b0;
        release_seq("after rst");

        // Button and software request in the same cycle: button wins
        rs_if.button_n = 1'b0;
        step(2 + DB_LAT);
        check_out("simul pending", 1'b0, 1'b1, 1'b1);
        rs_if.soft_reset_req = 1'b1;
        step(1);
        check_out("simul assert", 1'b1, 1'b0, 1'b0);
        check_cause("simul", 2'd1);
        rs_if.soft_reset_req = 1'b0;
        rs_if.button_n       = 1'b1;
        step(2 + DB_LAT);
        release_seq("simul");
        check_cause("simul done", 2'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
